// File: rtl/volume_ramp.sv
// -----------------------------------------------------------------------------
// volume_ramp
//   Stereo gain stage that sits between the sine generator and the sample FIFO.
//   Each accepted sample pair is scaled by the current gain. The result is
//   registered into a single output stage. The gain then steps toward the
//   effective target by RAMP_STEP per accepted sample, so level changes and
//   mute never produce a pop.
//
// Parameters
//   DW        signed sample width per channel
//   GW        gain width, unsigned Q1.(GW-1); 2^(GW-1) is unity
//   RAMP_STEP gain change per accepted sample (1 .. 2^GW-1)
//
// Ports
//   clk, arst_n        clock, asynchronous active-low reset
//   s_data/valid/ready input stream, s_data = {left, right}
//   m_data/valid/ready output stream toward the FIFO, m_data = {left, right}
//   target_gain        requested gain, sampled every cycle
//   mute               forces the effective target to 0
//   cur_gain           gain currently applied to accepted samples
//   ramp_busy          high while the gain is still moving (UP or DOWN)
// -----------------------------------------------------------------------------
module volume_ramp #(
  parameter int DW        = 24,
  parameter int GW        = 8,
  parameter int RAMP_STEP = 1
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic [2*DW-1:0] s_data,
  input  logic            s_valid,
  output logic            s_ready,
  output logic [2*DW-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready,
  input  logic [GW-1:0]   target_gain,
  input  logic            mute,
  output logic [GW-1:0]   cur_gain,
  output logic            ramp_busy
);

  typedef enum logic [1:0] {IDLE, UP, DOWN, MUTED} state_t;

  // Product width: signed DW times a zero-extended (GW+1)-bit gain.
  localparam int PW = DW + GW + 1;
  localparam logic signed [PW-1:0] SAT_MAX = {{(GW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(GW+2){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [GW:0]   STEP_W = (GW+1)'(RAMP_STEP);
  localparam logic [GW-1:0] STEP_G = GW'(RAMP_STEP);

  state_t          state_q, state_d;
  logic [GW-1:0]   gain_q, gain_d;
  logic [2*DW-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic [GW-1:0]   eff_target;
  logic            accept;

  // Floor-scaled, saturated channel value. The arithmetic shift rounds toward
  // minus infinity, so small negative inputs stay negative.
  function automatic logic [DW-1:0] scale(input logic [DW-1:0] sample,
                                          input logic [GW-1:0] gain);
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    prod    = $signed({{(GW+1){sample[DW-1]}}, sample}) *
              $signed({{(DW+1){1'b0}}, gain});
    shifted = prod >>> (GW-1);
    if (shifted > SAT_MAX)      shifted = SAT_MAX;
    else if (shifted < SAT_MIN) shifted = SAT_MIN;
    return shifted[DW-1:0];
  endfunction

  assign eff_target = mute ? '0 : target_gain;
  // Depends only on registered state and m_ready, never on s_valid.
  assign s_ready    = !valid_q || m_ready;
  assign accept     = s_valid && s_ready;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    valid_d = valid_q;
    data_d  = data_q;
    gain_d  = gain_q;
    state_d = IDLE;

    // Output stage: load on accept, drop valid after a bare transfer, hold
    // everything under backpressure.
    if (accept) begin
      valid_d = 1'b1;
      data_d  = {scale(s_data[2*DW-1:DW], gain_q), scale(s_data[DW-1:0], gain_q)};
    end else if (m_ready) begin
      valid_d = 1'b0;
    end

    // The gain moves only on accepts. It lands exactly on the target when the
    // target is within one step, so it cannot overshoot or wrap.
    if (accept) begin
      if (eff_target > gain_q) begin
        if (({1'b0, eff_target} - {1'b0, gain_q}) <= STEP_W) gain_d = eff_target;
        else                                                  gain_d = gain_q + STEP_G;
      end else if (eff_target < gain_q) begin
        if (({1'b0, gain_q} - {1'b0, eff_target}) <= STEP_W) gain_d = eff_target;
        else                                                  gain_d = gain_q - STEP_G;
      end
    end

    // The state is re-evaluated every cycle, so a mute release shows UP even
    // before the next sample arrives.
    if (gain_d < eff_target)           state_d = UP;
    else if (gain_d > eff_target)      state_d = DOWN;
    else if (mute && (gain_d == '0))   state_d = MUTED;
    else                               state_d = IDLE;
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // independent of process ordering in simulation.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      // NOTE: the output data register is reset too, so m_data reads 0 (not
      // stale audio) while reset is held.
      valid_q <= 1'b0;
      data_q  <= '0;
      gain_q  <= '0;
      state_q <= IDLE;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      gain_q  <= gain_d;
      state_q <= state_d;
    end
  end

  assign m_valid   = valid_q;
  assign m_data    = data_q;
  assign cur_gain  = gain_q;
  assign ramp_busy = (state_q == UP) || (state_q == DOWN);

endmodule

// File: tb/tb_volume_ramp.sv
// -----------------------------------------------------------------------------
// tb_volume_ramp
//   Two instances share the clock and reset. u_dut0 uses RAMP_STEP=1 and
//   u_dut1 uses RAMP_STEP=16. A one-slot behavioural model per instance
//   predicts m_valid, m_data, s_ready, cur_gain and ramp_busy, and these are
//   compared every negative edge. Directed sequences add literal expectations
//   for ramp-up, saturation, backpressure, mute, landing/reversal and
//   asynchronous reset.
// -----------------------------------------------------------------------------
module tb_volume_ramp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_n = 1'b0;

  logic [47:0] s_data0 = '0, s_data1 = '0;
  logic        s_valid0 = 1'b0, s_valid1 = 1'b0;
  logic        s_ready0, s_ready1;
  logic [47:0] m_data0, m_data1;
  logic        m_valid0, m_valid1;
  logic        m_ready0 = 1'b0, m_ready1 = 1'b0;
  logic [7:0]  target_gain0 = '0, target_gain1 = '0;
  logic        mute0 = 1'b0, mute1 = 1'b0;
  logic [7:0]  cur_gain0, cur_gain1;
  logic        ramp_busy0, ramp_busy1;

  volume_ramp #(.DW(24), .GW(8), .RAMP_STEP(1)) u_dut0 (
    .clk(clk), .arst_n(arst_n),
    .s_data(s_data0), .s_valid(s_valid0), .s_ready(s_ready0),
    .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready0),
    .target_gain(target_gain0), .mute(mute0),
    .cur_gain(cur_gain0), .ramp_busy(ramp_busy0)
  );

  volume_ramp #(.DW(24), .GW(8), .RAMP_STEP(16)) u_dut1 (
    .clk(clk), .arst_n(arst_n),
    .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
    .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1),
    .target_gain(target_gain1), .mute(mute1),
    .cur_gain(cur_gain1), .ramp_busy(ramp_busy1)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          g  [2];   // gain applied to the next accepted sample
  bit          ev [2];   // output slot occupied
  logic [47:0] ed [2];   // output slot contents
  bit          eb [2];   // gain still away from the effective target

  function automatic logic [23:0] mscale(input logic [23:0] s, input int gain);
    longint p;
    p = longint'($signed(s)) * gain;
    p = p >>> 7;                        // floor division by 128
    if (p > 8388607)  p = 8388607;
    if (p < -8388608) p = -8388608;
    return p[23:0];
  endfunction

  task automatic model_step(input int k, input int step, input bit sv,
                            input logic [47:0] sd, input bit mr,
                            input logic [7:0] tg, input bit mu);
    int e;
    bit acc;
    e   = mu ? 0 : int'(tg);
    acc = sv && (!ev[k] || mr);
    if (ev[k] && mr) ev[k] = 1'b0;
    if (acc) begin
      ev[k] = 1'b1;
      ed[k] = {mscale(sd[47:24], g[k]), mscale(sd[23:0], g[k])};
      if (e > g[k])      g[k] = (e - g[k] <= step) ? e : g[k] + step;
      else if (e < g[k]) g[k] = (g[k] - e <= step) ? e : g[k] - step;
    end
    eb[k] = (g[k] != e);
  endtask

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int k = 0; k < 2; k++) begin
        g[k] = 0; ev[k] = 1'b0; ed[k] = '0; eb[k] = 1'b0;
      end
    end else begin
      model_step(0, 1,  s_valid0, s_data0, m_ready0, target_gain0, mute0);
      model_step(1, 16, s_valid1, s_data1, m_ready1, target_gain1, mute1);
    end
  end

  // ---------------- per-cycle compare + output collector ----------------
  bit          collect = 1'b0;
  logic [47:0] got[$];

  always @(negedge clk) begin
    check("m_valid0", m_valid0, ev[0]);
    if (ev[0]) check("m_data0", m_data0, ed[0]);
    check("s_ready0", s_ready0, !ev[0] || m_ready0);
    check("cur_gain0", cur_gain0, g[0]);
    check("ramp_busy0", ramp_busy0, eb[0]);
    check("m_valid1", m_valid1, ev[1]);
    if (ev[1]) check("m_data1", m_data1, ed[1]);
    check("s_ready1", s_ready1, !ev[1] || m_ready1);
    check("cur_gain1", cur_gain1, g[1]);
    check("ramp_busy1", ramp_busy1, eb[1]);
    if (collect && m_valid0 && m_ready0) got.push_back(m_data0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int  n;
    int  cycle;
    bit  acc;
    logic [23:0] v;

    repeat (3) cyc();
    check("rst_m_valid", m_valid0, 1'b0);
    check("rst_m_data", m_data0, 48'h0);
    check("rst_cur_gain", cur_gain0, 8'h00);
    check("rst_ramp_busy", ramp_busy0, 1'b0);
    check("rst_s_ready", s_ready0, 1'b1);
    arst_n = 1'b1;

    // Landing and reversal with RAMP_STEP=16.
    target_gain1 = 8'h80; s_valid1 = 1'b1; m_ready1 = 1'b1;
    repeat (8) cyc();
    check("s16_unity", cur_gain1, 8'h80);
    target_gain1 = 8'h85; cyc();
    check("s16_land", cur_gain1, 8'h85);
    target_gain1 = 8'hF0; cyc();
    check("s16_up", cur_gain1, 8'h95);
    check("s16_up_busy", ramp_busy1, 1'b1);
    target_gain1 = 8'h10; cyc();
    check("s16_reverse", cur_gain1, 8'h85);
    check("s16_down_busy", ramp_busy1, 1'b1);
    repeat (8) cyc();
    check("s16_land_low", cur_gain1, 8'h10);
    check("s16_idle", ramp_busy1, 1'b0);
    s_valid1 = 1'b0;

    // Ramp-up from reset with RAMP_STEP=1.
    target_gain0 = 8'h80; s_data0 = {24'h100000, 24'h100000};
    s_valid0 = 1'b1; m_ready0 = 1'b1;
    cyc();
    check("up_first_out", m_data0, 48'h0);
    check("up_first_valid", m_valid0, 1'b1);
    check("up_gain1", cur_gain0, 8'h01);
    check("up_busy", ramp_busy0, 1'b1);
    repeat (127) cyc();
    check("up_gain128", cur_gain0, 8'h80);
    check("up_idle", ramp_busy0, 1'b0);
    check("up_out128", m_data0, {24'h0FE000, 24'h0FE000});
    cyc();
    check("up_out129", m_data0, {24'h100000, 24'h100000});

    // Saturation at gain 0xFF. floor(-255/128) is -2.
    target_gain0 = 8'hFF; s_data0 = '0;
    repeat (127) cyc();
    check("sat_gain", cur_gain0, 8'hFF);
    s_data0 = {24'h7FFFFF, 24'h800000}; cyc();
    check("sat_extremes", m_data0, {24'h7FFFFF, 24'h800000});
    s_data0 = {24'h400000, 24'hFFFFFF}; cyc();
    check("sat_half_neg1", m_data0, {24'h7F8000, 24'hFFFFFE});

    // Back to unity, then drain before streaming.
    target_gain0 = 8'h80; s_data0 = '0;
    repeat (127) cyc();
    check("bp_unity", cur_gain0, 8'h80);
    s_valid0 = 1'b0;
    repeat (2) cyc();

    // Backpressure: incrementing stream, m_ready low for 5 cycles.
    got.delete();
    collect  = 1'b1;
    n        = 1;
    cycle    = 0;
    s_data0  = {24'd1, 24'd1};
    s_valid0 = 1'b1;
    while (n <= 20 && cycle < 200) begin
      @(negedge clk);
      acc = s_valid0 && s_ready0;
      if (!m_ready0 && m_valid0) check("bp_s_ready_low", s_ready0, 1'b0);
      @(posedge clk); #1;
      cycle++;
      if (acc) n++;
      v        = 24'(n);
      s_data0  = {v, v};
      s_valid0 = (n <= 20);
      m_ready0 = !(cycle >= 5 && cycle < 10);
    end
    check("bp_done_in_budget", n, 21);
    s_valid0 = 1'b0; m_ready0 = 1'b1;
    repeat (3) cyc();
    collect = 1'b0;
    check("bp_count", got.size(), 20);
    for (int j = 0; j < got.size() && j < 20; j++) begin
      v = 24'(j + 1);
      check("bp_seq", got[j], {v, v});
    end

    // Mute at unity, then release.
    s_data0 = {24'h100000, 24'h100000}; s_valid0 = 1'b1; mute0 = 1'b1;
    repeat (128) cyc();
    check("mute_gain0", cur_gain0, 8'h00);
    check("mute_not_busy", ramp_busy0, 1'b0);
    cyc();
    check("mute_out0", m_data0, 48'h0);
    mute0 = 1'b0; s_valid0 = 1'b0; cyc();
    check("unmute_busy", ramp_busy0, 1'b1);
    check("unmute_hold", cur_gain0, 8'h00);
    s_valid0 = 1'b1;
    repeat (128) cyc();
    check("unmute_unity", cur_gain0, 8'h80);

    // Asynchronous reset mid-ramp with the output stage stalled.
    target_gain0 = 8'h20;
    repeat (10) cyc();
    m_ready0 = 1'b0; cyc();
    check("ar_pre_valid", m_valid0, 1'b1);
    #2 arst_n = 1'b0;
    #1;
    check("ar_m_valid", m_valid0, 1'b0);
    check("ar_m_data", m_data0, 48'h0);
    check("ar_cur_gain", cur_gain0, 8'h00);
    check("ar_busy", ramp_busy0, 1'b0);
    cyc();
    arst_n = 1'b1; target_gain0 = 8'h80; m_ready0 = 1'b1;
    s_data0 = {24'h100000, 24'h100000};
    cyc();
    check("ar_ramp_in", m_data0, 48'h0);
    check("ar_gain1", cur_gain0, 8'h01);

    repeat (2) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
